// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on magnitudes, with 1-cycle divide-by-zero/overflow path.
module riscv_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              negr_q, negr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_div, s1, s2, div0, ovf, ge;
    logic [XLEN-1:0]   m1, m2, rem_n, res_fin;
    logic [XLEN:0]     sum, shl;
    logic [2*XLEN-1:0] step, prod;

    always_comb begin : datapath
        is_div = funct3[2];
        s1 = op1[XLEN-1] & (is_div ? ~funct3[0]
                                   : (funct3 == 3'b001 || funct3 == 3'b010));
        s2 = op2[XLEN-1] & (is_div ? ~funct3[0] : (funct3 == 3'b001));
        m1 = s1 ? -op1 : op1;
        m2 = s2 ? -op2 : op2;
        div0 = is_div && (op2 == '0);
        ovf = is_div && !funct3[0]
              && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

        // acc holds {partial product, multiplier} or {remainder, quotient}
        sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        shl = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge = (shl >= {1'b0, a_q});
        rem_n = ge ? XLEN'(shl - {1'b0, a_q}) : shl[XLEN-1:0];
        if (fn_q[2]) begin
            step = {rem_n, acc_q[XLEN-2:0], ge};
        end else begin
            step = {sum, acc_q[XLEN-1:1]};
        end

        prod = neg_q ? -step : step;
        if (!fn_q[2]) begin
            res_fin = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                           : prod[2*XLEN-1:XLEN];
        end else if (fn_q[1]) begin
            res_fin = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        end else begin
            res_fin = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        a_d     = a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    fn_d   = funct3;
                    neg_d  = s1 ^ s2;
                    negr_d = s1;
                    cnt_d  = '0;
                    if (div0) begin
                        res_d   = funct3[1] ? op1 : '1;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (ovf) begin
                        res_d   = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, is_div ? m1 : m2};
                        a_d     = is_div ? m2 : m1;
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    res_d   = res_fin;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fn_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: directed RV32M vectors, handshake
// latency, ignored restarts and asynchronous reset abort.
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010,
                           MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101,
                           REM = 3'b110, REMU = 3'b111;

    riscv_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h want no done",
                         result);
            end else begin
                check("result", result, expq.pop_front());
            end
        end
    end

    task automatic scramble();
        op1    = $urandom;
        op2    = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic wait_done(input string nm, input int lat, input int bsy);
        int got_lat;
        int busyc;
        got_lat = 0;
        busyc   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyc++;
            if (done === 1'b1) begin
                got_lat = i;
                break;
            end
        end
        check({nm, "_latency"}, 32'(got_lat), 32'(lat));
        check({nm, "_busy_cycles"}, 32'(busyc), 32'(bsy));
        @(negedge clk);
        check({nm, "_done_width"}, {31'b0, done}, 32'd0);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special);
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
        expq.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        if (special) wait_done(nm, 1, 0);
        else wait_done(nm, 33, 32);
    endtask

    task automatic no_done_window(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check(nm, 32'(n), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op1    = '0;
        op2    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        run_op("mul_neg", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            scramble();
            check("result_hold", result, 32'hFFFF_FFEB);
        end

        run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 0);
        run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 0);
        run_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 0);
        run_op("mulh_neg", MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 0);
        run_op("mul_zero", MUL, 32'd0, 32'h0001_2345, 32'd0, 0);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("rem_negdiv", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu", REMU, 32'd100, 32'd7, 32'd2, 0);

        run_op("divu_by0", DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", REM, 32'h1234, 32'd0, 32'h0000_1234, 1);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // restart attempt while busy must be ignored
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = DIVU;
        op1    = 32'd100;
        op2    = 32'd7;
        expq.push_back(32'd14);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = MUL;
        op1    = 32'd3;
        op2    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        wait_done("ignored_start", 28, 27);
        check("ignored_start_result", result, 32'd14);
        no_done_window("ignored_start_no_second_done");

        // asynchronous reset mid-operation
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = MUL;
        op1    = 32'd5;
        op2    = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        no_done_window("abort_no_done");
        run_op("mul_after_rst", MUL, 32'd5, 32'd5, 32'd25, 0);

        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
